// File: rtl/ru_write_queue.sv
// In-order register write-back queue draining into the register file one write per cycle.
// Latency: a push into an empty queue is on rf_* the next cycle; rf_hold stalls the drain, a full queue drops in_ready.
module ru_write_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_rd,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       rf_hold,
  output logic                       rf_wr_en,
  output logic [ADDR_W-1:0]          rf_rd,
  output logic [DATA_W-1:0]          rf_data,
  input  logic [ADDR_W-1:0]          q_rs1,
  input  logic [ADDR_W-1:0]          q_rs2,
  output logic                       q_pend1,
  output logic                       q_pend2,
  output logic [DATA_W-1:0]          q_data1,
  output logic [DATA_W-1:0]          q_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              push;
  logic              pop;

  assign in_ready = (count < CW'(DEPTH));
  assign rf_wr_en = (count != '0) && !rf_hold;
  assign rf_rd    = (count != '0) ? rd_mem[head]   : '0;
  assign rf_data  = (count != '0) ? data_mem[head] : '0;

  // Writes to x0 are accepted but never stored.
  assign push = in_valid && in_ready && (in_rd != '0);
  assign pop  = rf_wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        rd_mem[tail]   <= in_rd;
        data_mem[tail] <= in_data;
        vld[tail]      <= 1'b1;
        tail           <= tail + 1'b1;
      end
      // head and tail only coincide when empty (no pop) or full (no push)
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] q);
    logic [DATA_W:0] r;
    logic [PW-1:0]   idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld[idx] && (rd_mem[idx] == q) && (q != '0))
        r = {1'b1, data_mem[idx]};
    end
    return r;
  endfunction

  always_comb begin
    {q_pend1, q_data1} = lookup(q_rs1);
    {q_pend2, q_data2} = lookup(q_rs2);
  end

endmodule

// File: tb/tb_ru_write_queue.sv
// Directed self-checking bench for ru_write_queue.
module tb_ru_write_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        rf_hold;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [4:0]  q_rs1, q_rs2;
  logic        q_pend1, q_pend2;
  logic [31:0] q_data1, q_data2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  ru_write_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .rf_hold(rf_hold), .rf_wr_en(rf_wr_en),
    .rf_rd(rf_rd), .rf_data(rf_data), .q_rs1(q_rs1), .q_rs2(q_rs2),
    .q_pend1(q_pend1), .q_pend2(q_pend2), .q_data1(q_data1), .q_data2(q_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  // Offer one write for exactly one rising edge; returns 1 time unit after that edge.
  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_rf_wr_en got %b exp 0", rf_wr_en); end
    checks++; if (rf_rd !== 5'd0 || rf_data !== 32'd0) begin errors++; $display("FAIL reset_rf_bus got rd=%0d data=%h exp 0/0", rf_rd, rf_data); end
    checks++; if (q_pend1 !== 1'b0 || q_data1 !== 32'd0) begin errors++; $display("FAIL reset_q1 got %b/%h exp 0/0", q_pend1, q_data1); end
    #10 rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    rf_hold = 1'b0;
    push(5'd5, 32'hDEADBEEF);
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en got %b exp 1", rf_wr_en); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL single_rd got %0d exp 5", rf_rd); end
    checks++; if (rf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", rf_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_n1 got %0d exp 1", count); end
    tick();
    checks++; if (count !== 3'd0 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL single_drained got count=%0d wr_en=%b exp 0/0", count, rf_wr_en); end
  endtask

  task automatic test_x0();
    q_rs1 = 5'd0;
    push(5'd0, 32'h1234);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL x0_count got %0d exp 0", count); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en got %b exp 0", rf_wr_en); end
    checks++; if (q_pend1 !== 1'b0) begin errors++; $display("FAIL x0_pend got %b exp 0", q_pend1); end
  endtask

  task automatic test_fill();
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'hA0 + 32'(i));
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL fill_hold_wr_en got %b exp 0", rf_wr_en); end
    push(5'd9, 32'h99);
    q_rs1 = 5'd9;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_count got %0d exp 4", count); end
    checks++; if (q_pend1 !== 1'b0) begin errors++; $display("FAIL fill_fifth_pend got %b exp 0", q_pend1); end
    rf_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if (rf_wr_en !== 1'b1 || rf_rd !== 5'(i) || rf_data !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL fill_drain%0d got en=%b rd=%0d data=%h exp 1/%0d/%h", i, rf_wr_en, rf_rd, rf_data, i, 32'hA0 + 32'(i));
      end
      tick();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_empty got %0d exp 0", count); end
  endtask

  task automatic test_forward();
    rf_hold = 1'b1;
    q_rs1 = 5'd7;
    q_rs2 = 5'd8;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    checks++; if (q_pend1 !== 1'b1 || q_data1 !== 32'h22) begin errors++; $display("FAIL fwd_youngest got %b/%h exp 1/22", q_pend1, q_data1); end
    checks++; if (q_pend2 !== 1'b0 || q_data2 !== 32'h0) begin errors++; $display("FAIL fwd_q2_none got %b/%h exp 0/0", q_pend2, q_data2); end
    push(5'd8, 32'h33);
    checks++; if (q_pend2 !== 1'b1 || q_data2 !== 32'h33) begin errors++; $display("FAIL fwd_q2 got %b/%h exp 1/33", q_pend2, q_data2); end
    rf_hold = 1'b0;
    tick();
    checks++; if (q_pend1 !== 1'b1 || q_data1 !== 32'h22) begin errors++; $display("FAIL fwd_partial got %b/%h exp 1/22", q_pend1, q_data1); end
    tick();
    checks++; if (q_pend1 !== 1'b0 || q_data1 !== 32'h0) begin errors++; $display("FAIL fwd_drained got %b/%h exp 0/0", q_pend1, q_data1); end
    tick();
    checks++; if (count !== 3'd0 || q_pend2 !== 1'b0) begin errors++; $display("FAIL fwd_empty got count=%0d pend2=%b exp 0/0", count, q_pend2); end
  endtask

  task automatic test_back_to_back();
    rf_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_rd    = 5'(i + 1);
      in_data  = 32'h100 + 32'(i);
      tick();
      checks++;
      if (count !== 3'd1 || rf_rd !== 5'(i + 1) || rf_data !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_%0d got count=%0d rd=%0d data=%h exp 1/%0d/%h", i, count, rf_rd, rf_data, i + 1, 32'h100 + 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid();
    int writes;
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(5'(10 + i), 32'hC0 + 32'(i));
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 3", count); end
    #2;
    rf_hold = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got %b exp 0", rf_wr_en); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
    #1 rst = 1'b0;
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rf_wr_en === 1'b1) writes++;
    end
    checks++; if (writes !== 0) begin errors++; $display("FAIL rstmid_no_write got %0d writes exp 0", writes); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
    rf_hold = 1'b0; q_rs1 = '0; q_rs2 = '0;
    test_reset();
    test_single();
    test_x0();
    test_fill();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
